// File: rtl/led_write_arbiter_pkg.sv
// Shared definitions for the LED write arbiter: FSM state encodings and requester geometry.
package led_write_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/led_write_arbiter_if.sv
// Requester/LED-register bundle seen by the arbiter; the slave side is the arbiter itself.
interface led_write_arbiter_if;
    import led_write_arbiter_pkg::*;

    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*SLICE_W-1:0] data_i;
    logic [NUM_REQ-1:0]         ack_o;
    logic                       en_o;
    logic [SLICE_W-1:0]         d_o;
    logic                       busy_o;

    modport master (
        output req_i, data_i,
        input  ack_o, en_o, d_o, busy_o
    );

    modport slave (
        input  req_i, data_i,
        output ack_o, en_o, d_o, busy_o
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first pending request after 'last', wrapping.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        valid = |req;
        idx   = last;
        cand  = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/led_write_arbiter.sv
// Shares the single enable-gated LED register among four requesters, one write per grant,
// with a programmable hold gap after every write so each value stays visible.
module led_write_arbiter
    import led_write_arbiter_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic              clk50m_i,
    input  logic              rst_i,
    led_write_arbiter_if.slave bus
);

    // state | meaning
    // IDLE  | waiting for any request; all outputs low
    // GRANT | one-cycle write of the winner's slice, ack pulse
    // HOLD  | gap of HOLD_CYCLES cycles before the next arbitration

    localparam int                HOLD_LOAD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]  HOLD_LOAD   = CNT_W'(HOLD_LOAD_I);

    state_t               state_q;
    logic [1:0]           last_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 en_q;
    logic [SLICE_W-1:0]   d_q;
    logic                 busy_q;

    logic                 pick_valid;
    logic [1:0]           pick_idx;

    rr_pick4 u_pick (
        .req   (bus.req_i),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            en_q  <= 1'b0;
            d_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= ST_GRANT;
                        ack_q   <= NUM_REQ'(1) << pick_idx;
                        en_q    <= 1'b1;
                        d_q     <= bus.data_i[{pick_idx, 2'b00} +: SLICE_W];
                        last_q  <= pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (HOLD_CYCLES == 0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.en_o   = en_q;
    assign bus.d_o    = d_q;
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_led_write_arbiter.sv
// Directed bench for led_write_arbiter: one instance with a 4-cycle hold, one with no hold.
module tb_led_write_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #10 clk = ~clk;

    led_write_arbiter_if bus4 ();
    led_write_arbiter_if bus0 ();

    led_write_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) u_dut4 (
        .clk50m_i (clk),
        .rst_i    (rst),
        .bus      (bus4)
    );

    led_write_arbiter #(.HOLD_CYCLES(0), .CNT_W(1)) u_dut0 (
        .clk50m_i (clk),
        .rst_i    (rst),
        .bus      (bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4(input int n);
        bus4.req_i = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.req_i = '0; bus4.data_i = '0;
        bus0.req_i = '0; bus0.data_i = '0;
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.en_o, bus4.d_o, bus4.busy_o} !== 10'b0) begin
            n_fail++; $display("FAIL reset_dut4: got %b want 0", {bus4.ack_o, bus4.en_o, bus4.d_o, bus4.busy_o});
        end
        n_tests++;
        if ({bus0.ack_o, bus0.en_o, bus0.d_o, bus0.busy_o} !== 10'b0) begin
            n_fail++; $display("FAIL reset_dut0: got %b want 0", {bus0.ack_o, bus0.en_o, bus0.d_o, bus0.busy_o});
        end
        rst = 1'b0;
        bus4.req_i = 4'b0001; bus4.data_i = 16'h000A;
        tick();
        bus4.req_i = '0;
        tick();
        tick();
        n_tests++;
        if (bus4.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_in_hold: got %b want 1", bus4.busy_o);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.en_o, bus4.d_o, bus4.busy_o} !== 10'b0) begin
            n_fail++; $display("FAIL reset_mid_hold: got %b want 0", {bus4.ack_o, bus4.en_o, bus4.d_o, bus4.busy_o});
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({bus4.en_o, bus4.busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL no_reissue: en/busy got %b want 00", {bus4.en_o, bus4.busy_o});
        end
        bus4.req_i = 4'b0100; bus4.data_i = 16'h0500;
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.en_o, bus4.d_o} !== {4'b0100, 1'b1, 4'h5}) begin
            n_fail++; $display("FAIL post_reset_grant: ack/en/d got %b/%b/%h want 0100/1/5",
                               bus4.ack_o, bus4.en_o, bus4.d_o);
        end
        idle4(6);
    endtask

    task automatic test_single();
        int b;
        int e;
        bus4.req_i = 4'b0001; bus4.data_i = 16'h000A;
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.en_o, bus4.d_o} !== {4'b0001, 1'b1, 4'hA}) begin
            n_fail++; $display("FAIL single_grant: ack/en/d got %b/%b/%h want 0001/1/a",
                               bus4.ack_o, bus4.en_o, bus4.d_o);
        end
        b = int'(bus4.busy_o);
        e = int'(bus4.en_o);
        bus4.req_i = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            b += int'(bus4.busy_o);
            e += int'(bus4.en_o);
        end
        n_tests++;
        if (b != 5) begin
            n_fail++; $display("FAIL single_busy_len: got %0d want 5", b);
        end
        n_tests++;
        if (e != 1) begin
            n_fail++; $display("FAIL single_en_len: got %0d want 1", e);
        end
    endtask

    task automatic test_round_robin();
        int k;
        int prev;
        logic [3:0] exp_d;
        logic [3:0] exp_ack;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus4.req_i = 4'hF; bus4.data_i = 16'h4321;
        k = 0;
        prev = 0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (bus4.en_o === 1'b1) begin
                exp_d   = 4'((k % 4) + 1);
                exp_ack = 4'(1 << (k % 4));
                n_tests++;
                if ({bus4.ack_o, bus4.d_o} !== {exp_ack, exp_d}) begin
                    n_fail++; $display("FAIL rr_grant%0d: ack/d got %b/%h want %b/%h",
                                       k, bus4.ack_o, bus4.d_o, exp_ack, exp_d);
                end
                n_tests++;
                if ((k == 0 && i != 1) || (k > 0 && i - prev != 6)) begin
                    n_fail++; $display("FAIL rr_spacing%0d: grant at cycle %0d, previous %0d, want gap 6",
                                       k, i, prev);
                end
                prev = i;
                k++;
            end
        end
        n_tests++;
        if (k != 5) begin
            n_fail++; $display("FAIL rr_count: got %0d grants want 5", k);
        end
        idle4(8);
    endtask

    task automatic test_fairness();
        int e;
        bus4.req_i = 4'b0100; bus4.data_i = 16'h0600;
        tick();
        n_tests++;
        if (bus4.ack_o !== 4'b0100) begin
            n_fail++; $display("FAIL fair_setup: ack got %b want 0100", bus4.ack_o);
        end
        idle4(6);
        bus4.req_i = 4'b0101; bus4.data_i = 16'h0801;
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.d_o} !== {4'b0001, 4'h1}) begin
            n_fail++; $display("FAIL fair_after2: ack/d got %b/%h want 0001/1", bus4.ack_o, bus4.d_o);
        end
        e = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            e += int'(bus4.en_o);
        end
        tick();
        n_tests++;
        if ({bus4.ack_o, bus4.d_o} !== {4'b0100, 4'h8} || e != 0) begin
            n_fail++; $display("FAIL fair_after0: ack/d got %b/%h (gap en %0d) want 0100/8 (gap en 0)",
                               bus4.ack_o, bus4.d_o, e);
        end
        idle4(8);
    endtask

    task automatic test_ignored();
        int e;
        bus4.req_i = 4'b0001; bus4.data_i = 16'h0007;
        tick();
        n_tests++;
        if ({bus4.en_o, bus4.d_o} !== {1'b1, 4'h7}) begin
            n_fail++; $display("FAIL ign_grant: en/d got %b/%h want 1/7", bus4.en_o, bus4.d_o);
        end
        bus4.req_i = '0; bus4.data_i = 16'h0009;
        #2;
        n_tests++;
        if (bus4.d_o !== 4'h7) begin
            n_fail++; $display("FAIL ign_data_grant: d got %h want 7", bus4.d_o);
        end
        tick();
        n_tests++;
        if ({bus4.en_o, bus4.d_o} !== {1'b0, 4'h0}) begin
            n_fail++; $display("FAIL ign_hold_out: en/d got %b/%h want 0/0", bus4.en_o, bus4.d_o);
        end
        e = 0;
        tick();
        bus4.req_i = 4'b1000;
        tick(); e += int'(bus4.en_o);
        tick(); e += int'(bus4.en_o);
        bus4.req_i = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            e += int'(bus4.en_o);
        end
        n_tests++;
        if (e != 0) begin
            n_fail++; $display("FAIL ign_pulse: got %0d grants want 0", e);
        end
    endtask

    task automatic test_hold0();
        logic exp_on;
        logic [3:0] exp_ack;
        logic [3:0] exp_d;
        bus0.req_i = 4'b0011; bus0.data_i = 16'h00DC;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_on  = (i % 2 == 1);
            exp_ack = !exp_on ? 4'b0000 : ((i % 4 == 1) ? 4'b0001 : 4'b0010);
            exp_d   = !exp_on ? 4'h0 : ((i % 4 == 1) ? 4'hC : 4'hD);
            n_tests++;
            if ({bus0.en_o, bus0.busy_o, bus0.ack_o, bus0.d_o} !== {exp_on, exp_on, exp_ack, exp_d}) begin
                n_fail++; $display("FAIL hold0_cycle%0d: en/busy/ack/d got %b/%b/%b/%h want %b/%b/%b/%h",
                                   i, bus0.en_o, bus0.busy_o, bus0.ack_o, bus0.d_o,
                                   exp_on, exp_on, exp_ack, exp_d);
            end
        end
        bus0.req_i = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_ignored();
        test_hold0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
